rot_arb_seq: RTL

//   Shares one rotate-right step unit between two requesters and sequences

---
 rtl/rot_ctrl_pkg.sv | 12 +
 rtl/rot_arb_seq_if.sv | 31 +++
 rtl/rot_arb_seq_step.sv | 14 +
 rtl/rot_arb_seq.sv | 86 ++++++++
 4 files changed

// File: rtl/rot_ctrl_pkg.sv
// Shared definitions for the rotate arbiter/sequencer: FSM encodings and
// step-unit limits.
package rot_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int STEP_MAX = 3;
    localparam int ID_W     = 1;
endpackage

// File: rtl/rot_arb_seq_if.sv
// Request (two requesters) and result handshake bundle for rot_arb_seq.
// master = requesters/consumer side, slave = the sequencer.
interface rot_arb_seq_if
    import rot_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int AW = $clog2(WIDTH);

    logic             req_valid_0;
    logic [WIDTH-1:0] req_data_0;
    logic [AW-1:0]    req_amt_0;
    logic             req_ready_0;
    logic             req_valid_1;
    logic [WIDTH-1:0] req_data_1;
    logic [AW-1:0]    req_amt_1;
    logic             req_ready_1;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [ID_W-1:0]  res_id;
    logic             res_ready;

    modport master (
        output req_valid_0, req_data_0, req_amt_0, req_valid_1, req_data_1, req_amt_1, res_ready,
        input  req_ready_0, req_ready_1, res_valid, res_data, res_id
    );
    modport slave (
        input  req_valid_0, req_data_0, req_amt_0, req_valid_1, req_data_1, req_amt_1, res_ready,
        output req_ready_0, req_ready_1, res_valid, res_data, res_id
    );
endinterface

// File: rtl/rot_arb_seq_step.sv
// Single-cycle rotate-right step unit: WIDTH bits by 0..3 positions.
module rot_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       amt,
    output logic [WIDTH-1:0] dout
);
    logic [2*WIDTH-1:0] dbl;

    // Shifting the doubled word right leaves the rotation in the low half.
    assign dbl  = {din, din} >> amt;
    assign dout = dbl[WIDTH-1:0];
endmodule

// File: rtl/rot_arb_seq.sv
// Round-robin shares one rotate step unit between two requesters and
// sequences arbitrary rotate-right amounts over several cycles.
module rot_arb_seq
    import rot_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    rot_arb_seq_if.slave  bus,
    output logic          busy
);
    localparam int AW = $clog2(WIDTH);

    state_t           state, nxt;
    logic [WIDTH-1:0] data_q, rot_out, win_data;
    logic [AW-1:0]    rem_q, rem_nxt, win_amt;
    logic [ID_W-1:0]  id_q, last_q, win_id;
    logic             any_req;
    logic [1:0]       step;

    // Winner: sole valid requester, or the one not served last when both are.
    always_comb begin
        any_req  = bus.req_valid_0 | bus.req_valid_1;
        win_id   = (bus.req_valid_0 && bus.req_valid_1) ? ~last_q : bus.req_valid_1;
        win_data = win_id[0] ? bus.req_data_1 : bus.req_data_0;
        win_amt  = win_id[0] ? bus.req_amt_1  : bus.req_amt_0;
    end

    assign bus.req_ready_0 = (state == IDLE) && bus.req_valid_0 && !win_id[0];
    assign bus.req_ready_1 = (state == IDLE) && bus.req_valid_1 &&  win_id[0];

    always_comb begin
        step    = (rem_q > AW'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];
        rem_nxt = rem_q - AW'(step);
    end

    rot_step #(.WIDTH(WIDTH)) u_step (
        .din  (data_q),
        .amt  (step),
        .dout (rot_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (any_req) nxt = (win_amt == '0) ? DONE : ROTATE;
            ROTATE:  if (rem_nxt == '0) nxt = DONE;
            DONE:    if (bus.res_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            rem_q  <= '0;
            id_q   <= '0;
            last_q <= ID_W'(1);
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    data_q <= win_data;
                    rem_q  <= win_amt;
                    id_q   <= win_id;
                end
                ROTATE: begin
                    data_q <= rot_out;
                    rem_q  <= rem_nxt;
                end
                DONE: if (bus.res_ready) last_q <= id_q;
                default: ;
            endcase
        end
    end

    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = data_q;
    assign bus.res_id    = id_q;
    assign busy          = (state != IDLE);
endmodule
